// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Width helper that never returns 0, so single-entry configs still get a 1-bit field.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NUM_REQ_DEF      = 4;
  localparam int unsigned MAX_BURST_DEF    = 4;
  localparam int unsigned FLUSH_CYCLES_DEF = 2;

  localparam int unsigned REQ_IDX_W = clog2_min1(NUM_REQ_DEF);
  localparam int unsigned BEAT_W    = clog2_min1(MAX_BURST_DEF + 1);
  localparam int unsigned FLUSH_W   = clog2_min1(FLUSH_CYCLES_DEF + 1);

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set bit of valid_i searching upward from rr_ptr_i.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  localparam int unsigned    SUM_W     = IDX_W + 1;
  localparam logic [IDX_W:0] NUM_REQ_W = SUM_W'(NUM_REQ);

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;
  logic [IDX_W-1:0]     offset;
  logic [IDX_W:0]       sum;

  // Rotating via a doubled vector keeps the select a plain part-select.
  assign doubled = {valid_i, valid_i};
  assign rotated = doubled[{1'b0, rr_ptr_i} +: NUM_REQ];

  always_comb begin
    found_o = 1'b0;
    offset  = '0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (rotated[i-1]) begin
        found_o = 1'b1;
        offset  = IDX_W'(i - 1);
      end
    end
    sum = {1'b0, offset} + {1'b0, rr_ptr_i};
    if (sum >= NUM_REQ_W) begin
      sum = sum - NUM_REQ_W;
    end
    idx_o = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers,
// with full-throttling and a timed FIFO clear sequence.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ      = 4,
  parameter  int unsigned DATA_W       = 16,
  parameter  int unsigned MAX_BURST    = 4,
  parameter  int unsigned FLUSH_CYCLES = 2,
  localparam int unsigned IDX_W        = clog2_min1(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      flush_req,
  output logic                      flush_done,
  input  logic                      fifo_full,
  output logic                      fifo_write_en,
  output logic [DATA_W-1:0]         fifo_data_in,
  output logic                      fifo_clear,
  output logic                      grant_valid,
  output logic [IDX_W-1:0]          grant_id
);

  localparam int unsigned BW = clog2_min1(MAX_BURST + 1);
  localparam int unsigned FW = clog2_min1(FLUSH_CYCLES + 1);

  localparam logic [BW-1:0]    LAST_BEAT  = BW'(MAX_BURST - 1);
  localparam logic [FW-1:0]    LAST_FLUSH = FW'(FLUSH_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [FW-1:0]      flush_cnt_q, flush_cnt_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;

  logic               owner_valid;
  logic               owner_last;
  logic [DATA_W-1:0]  owner_data;
  logic [NUM_REQ-1:0] owner_onehot;
  logic               accept;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid_i  (req_valid),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (pick_found),
    .idx_o    (pick_idx)
  );

  always_comb begin
    owner_valid  = 1'b0;
    owner_last   = 1'b0;
    owner_data   = '0;
    owner_onehot = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (owner_q == IDX_W'(r)) begin
        owner_valid     = req_valid[r];
        owner_last      = req_last[r];
        owner_data      = req_data[r*DATA_W +: DATA_W];
        owner_onehot[r] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    accept        = 1'b0;
    req_ready     = '0;
    fifo_write_en = 1'b0;
    fifo_data_in  = '0;
    fifo_clear    = 1'b0;
    flush_done    = 1'b0;
    grant_valid   = 1'b0;
    grant_id      = '0;

    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end else if (pick_found) begin
          state_d    = BURST;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end

      BURST: begin
        grant_valid   = 1'b1;
        grant_id      = owner_q;
        fifo_data_in  = owner_data;
        accept        = owner_valid & ~fifo_full;
        fifo_write_en = accept;
        req_ready     = owner_onehot & {NUM_REQ{accept}};
        if (accept) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (owner_last || (beat_cnt_q == LAST_BEAT)) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
          end
        end
      end

      FLUSH: begin
        fifo_clear  = 1'b1;
        flush_cnt_d = flush_cnt_q + FW'(1);
        if (flush_cnt_q == LAST_FLUSH) begin
          flush_done  = 1'b1;
          flush_cnt_d = '0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: vector table, directed corner cases,
// and a randomized run against a behavioural model with a per-requester scoreboard.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 4;
  localparam int FC = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last = '0;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            flush_req = 1'b0;
  logic            flush_done;
  logic            fifo_full = 1'b0;
  logic            fifo_write_en;
  logic [DW-1:0]   fifo_data_in;
  logic            fifo_clear;
  logic            grant_valid;
  logic [1:0]      grant_id;

  int errors = 0;
  int checks = 0;

  // Each requester streams {id, sequence number}; seq advances when the model accepts a beat.
  logic [11:0] seq [N];
  logic [11:0] wr_seq [N];

  // Reference model: owner (-1 = no grant), beats in burst, search pointer, clear cycles left.
  int m_owner, m_beats, m_ptr, m_flush_left;

  typedef struct {
    logic [3:0] v;
    logic [3:0] l;
    logic       full;
    logic       fl;
    logic       gv;
    logic [1:0] gid;
    logic       we;
    logic [3:0] rdy;
    logic       clr;
    logic       done;
  } vec_t;

  vec_t tbl [16];

  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < N; r++) req_data[r*DW +: DW] = {4'(r), seq[r]};
  end

  fifo_write_arbiter #(
    .NUM_REQ      (N),
    .DATA_W       (DW),
    .MAX_BURST    (MB),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .flush_req     (flush_req),
    .flush_done    (flush_done),
    .fifo_full     (fifo_full),
    .fifo_write_en (fifo_write_en),
    .fifo_data_in  (fifo_data_in),
    .fifo_clear    (fifo_clear),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic          inb;
    logic          acc;
    logic [N-1:0]  rdy;
    logic [DW-1:0] d;
    logic [3:0]    tag;
    inb = (m_owner >= 0);
    acc = 1'b0;
    rdy = '0;
    d   = '0;
    if (inb) begin
      acc = req_valid[m_owner] && !fifo_full;
      d   = {4'(m_owner), seq[m_owner]};
      if (acc) rdy[m_owner] = 1'b1;
    end
    chk("grant_valid",   32'(grant_valid),   32'(inb));
    chk("grant_id",      32'(grant_id),      inb ? 32'(m_owner) : 32'd0);
    chk("fifo_write_en", 32'(fifo_write_en), 32'(acc));
    chk("req_ready",     32'(req_ready),     32'(rdy));
    chk("fifo_data_in",  32'(fifo_data_in),  32'(d));
    chk("fifo_clear",    32'(fifo_clear),    32'(m_flush_left > 0));
    chk("flush_done",    32'(flush_done),    32'(m_flush_left == 1));
    chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    if (fifo_write_en) begin
      chk("write_while_full", 32'(fifo_full), 32'd0);
      tag = fifo_data_in[15:12];
      chk("write_tag_range", 32'(tag < 4'(N)), 32'd1);
      if (tag < 4'(N)) begin
        chk("write_order", 32'(fifo_data_in[11:0]), 32'(wr_seq[tag]));
        wr_seq[tag] = wr_seq[tag] + 12'd1;
      end
    end
  endtask

  task automatic model_update();
    if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (m_owner >= 0) begin
      if (req_valid[m_owner] && !fifo_full) begin
        seq[m_owner] = seq[m_owner] + 12'd1;
        m_beats++;
        if (req_last[m_owner] || m_beats == MB) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end else if (flush_req) begin
      m_flush_left = FC;
    end else begin
      for (int k = 0; k < N; k++) begin
        int r;
        r = (m_ptr + k) % N;
        if (req_valid[r] && m_owner < 0) begin
          m_owner = r;
          m_beats = 0;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_owner      = -1;
    m_beats      = 0;
    m_ptr        = 0;
    m_flush_left = 0;
  endtask

  task automatic eval();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    eval();
    adv();
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_grant_valid"}, 32'(grant_valid),   32'd0);
    chk({pfx, "_grant_id"},    32'(grant_id),      32'd0);
    chk({pfx, "_write_en"},    32'(fifo_write_en), 32'd0);
    chk({pfx, "_req_ready"},   32'(req_ready),     32'd0);
    chk({pfx, "_data_in"},     32'(fifo_data_in),  32'd0);
    chk({pfx, "_clear"},       32'(fifo_clear),    32'd0);
    chk({pfx, "_flush_done"},  32'(flush_done),    32'd0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    flush_req = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_all_zero("reset");
    rst = 1'b0;
  endtask

  initial begin
    int start;
    for (int r = 0; r < N; r++) begin
      seq[r]    = '0;
      wr_seq[r] = '0;
    end
    model_reset();

    //            v        l        full  fl    gv    gid    we    rdy      clr   done
    tbl[0]  = '{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b0, 1'b0};
    tbl[2]  = '{4'b0010, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b0, 1'b0};
    tbl[3]  = '{4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[4]  = '{4'b1010, 4'b1000, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b0, 1'b0};
    tbl[5]  = '{4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[6]  = '{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b0};
    tbl[7]  = '{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1};
    tbl[8]  = '{4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[9]  = '{4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[10] = '{4'b0010, 4'b0010, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b0, 1'b0};
    tbl[11] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[12] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b0};
    tbl[13] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1};
    tbl[14] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[15] = '{4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b0, 1'b0};

    #2;
    do_reset();

    // Vector table: early last, round-robin skip, flush priority, flush held off by a burst.
    for (int i = 0; i < 16; i++) begin
      req_valid = tbl[i].v;
      req_last  = tbl[i].l;
      fifo_full = tbl[i].full;
      flush_req = tbl[i].fl;
      eval();
      chk("tbl_grant_valid", 32'(grant_valid),   32'(tbl[i].gv));
      chk("tbl_grant_id",    32'(grant_id),      32'(tbl[i].gid));
      chk("tbl_write_en",    32'(fifo_write_en), 32'(tbl[i].we));
      chk("tbl_req_ready",   32'(req_ready),     32'(tbl[i].rdy));
      chk("tbl_clear",       32'(fifo_clear),    32'(tbl[i].clr));
      chk("tbl_flush_done",  32'(flush_done),    32'(tbl[i].done));
      if (tbl[i].gv)
        chk("tbl_data_owner", 32'(fifo_data_in[15:12]), 32'(tbl[i].gid));
      else
        chk("tbl_data_idle", 32'(fifo_data_in), 32'd0);
      adv();
    end

    // Asynchronous reset in the middle of requester 2's burst.
    do_reset();
    req_valid = 4'b0100;
    cycle();
    cycle();
    cycle();
    #1;
    chk("t1_grant_held", 32'(grant_valid), 32'd1);
    chk("t1_owner",      32'(grant_id),    32'd2);
    rst = 1'b1;
    #1;
    check_all_zero("t1_async");
    model_reset();
    req_valid = 4'b1111;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    eval();
    chk("t1_next_grant", 32'(grant_id), 32'd0);
    adv();

    // All requesters busy, no last: 0,1,2,3,0 with four writes and one bubble each.
    do_reset();
    req_valid = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      eval();
      chk("t2_bubble", 32'(grant_valid), 32'd0);
      adv();
      for (int k = 0; k < MB; k++) begin
        eval();
        chk("t2_owner", 32'(grant_id), 32'(b % N));
        chk("t2_write", 32'(fifo_write_en), 32'd1);
        adv();
      end
    end

    // Full for five cycles mid-burst: grant held, nothing written, then resumes in order.
    do_reset();
    start     = int'(wr_seq[0]);
    req_valid = 4'b0001;
    cycle();
    cycle();
    cycle();
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      eval();
      chk("t4_stall_we",  32'(fifo_write_en), 32'd0);
      chk("t4_stall_rdy", 32'(req_ready),     32'd0);
      chk("t4_stall_gv",  32'(grant_valid),   32'd1);
      chk("t4_stall_gid", 32'(grant_id),      32'd0);
      adv();
    end
    fifo_full = 1'b0;
    cycle();
    eval();
    chk("t4_resume", 32'(fifo_write_en), 32'd1);
    adv();
    eval();
    chk("t4_done", 32'(grant_valid), 32'd0);
    adv();
    chk("t4_count", 32'(int'(wr_seq[0]) - start), 32'd4);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_last  = 4'($urandom) & 4'($urandom);
      fifo_full = ($urandom_range(0, 9) < 3);
      flush_req = ($urandom_range(0, 49) == 0);
      cycle();
    end
    for (int r = 0; r < N; r++) begin
      chk("final_count", 32'(wr_seq[r]), 32'(seq[r]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
